pocket_audio_sched: RTL and testbench
=====================================

POCKET_AUDIO_SCHED -- requirements
Module: pocket_audio_sched

Interface
REQ-001 SHALL have parameter SCLK_DIV, default 12: system clocks per sclk_en strobe; legal range 2..255.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: sample-pair FIFO entries; power of two, 2..16.
REQ-003 SHALL have port clk_74a, input, 1: sole clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1: run the serial timebase when high.
REQ-006 SHALL have port mute, input, 1: force zero sample outputs when high.
REQ-007 SHALL have ports src0_valid/src1_valid, input, 1 each: requester has a sample pair.
REQ-008 SHALL have ports src0_data/src1_data, input, 32 each: {left[15:0], right[15:0]}.
REQ-009 SHALL have ports src0_ready/src1_ready, output, 1 each: sample accepted this cycle when ANDed with valid.
REQ-010 SHALL have port sclk_en, output, 1: one-cycle serial-clock strobe for the serializer.
REQ-011 SHALL have port frame_start, output, 1: one-cycle strobe at the L/R frame boundary.
REQ-012 SHALL have ports sample_l/sample_r, output, 16 each: held sample pair for the serializer.
REQ-013 SHALL have port fifo_level, output, 5: current FIFO occupancy, 0..FIFO_DEPTH.
REQ-014 SHALL have port underrun_cnt, output, 8: saturating count of empty-FIFO frame boundaries.

Function
REQ-015 SHALL count div_cnt 0..SCLK_DIV-1 while enable=1 and assert sclk_en for exactly the cycle where div_cnt=SCLK_DIV-1.
REQ-016 SHALL count bit_cnt 0..63 on each sclk_en, wrapping 63->0; 64 sclk_en strobes per frame (32 per channel).
REQ-017 SHALL assert frame_start in the same cycle as the sclk_en strobe at which bit_cnt=63.
REQ-018 SHALL, when enable=0, clear div_cnt and bit_cnt to 0 and hold sclk_en and frame_start low; FIFO contents, arbitration and sample outputs are unaffected.
REQ-019 SHALL arbitrate src0/src1 round-robin: with both valid, grant the source not granted last; with one valid, grant it; priority pointer updates only on an accepted transfer.
REQ-020 SHALL drive srcN_ready=1 only for the granted source and only when fifo_level<FIFO_DEPTH; ready for both sources is never high in the same cycle.
REQ-021 SHALL push at most one sample pair per cycle, on valid&ready; ready is combinational from valid, fifo_level and the pointer.
REQ-022 SHALL on the frame_start edge pop the FIFO head and load it into sample_l/sample_r, visible the cycle after frame_start.
REQ-023 SHALL, if the FIFO is empty at frame_start, hold sample_l/sample_r at their previous values and increment underrun_cnt, saturating at 255.
REQ-024 SHALL support push and pop in the same cycle, including on a full FIFO (ready evaluated before pop: full blocks the push) and on an empty FIFO (push enters FIFO, pop counts as underrun).
REQ-025 SHALL drive sample_l/sample_r to 0 while mute=1, combinationally; FIFO popping and held values continue unchanged underneath.
REQ-026 SHALL keep fifo_level exact: +1 on push only, -1 on pop only, unchanged on both or neither.

Reset
REQ-027 SHALL on reset=1 at a clock edge: div_cnt=0, bit_cnt=0, FIFO empty (fifo_level=0), sample_l=sample_r=0, underrun_cnt=0, priority pointer favouring src0, sclk_en=frame_start=0.
REQ-028 SHALL hold srcN_ready=0 while reset=1; reset mid-frame or mid-transfer discards FIFO contents and restarts the timebase from div_cnt=0 on the first cycle after release.

Verification
REQ-029 SCLK_DIV=4, enable=1 after reset -> sclk_en every 4th cycle starting cycle 4; frame_start every 256 cycles, first at cycle 256.
REQ-030 Both sources continuously valid, src0_data=0x11112222, src1_data=0x33334444 -> accepts alternate src0,src1,src0,...; FIFO fills to 4, both ready low while full.
REQ-031 FIFO empty at three consecutive frame_starts after a prior 0xAAAA5555 load -> sample_l=0xAAAA, sample_r=0x5555 held; underrun_cnt=3; with 300 empty frames underrun_cnt stays 255.
REQ-032 FIFO full (4) with src1 valid in the frame_start cycle -> src1_ready=0, fifo_level goes 4->3; next cycle src1_ready=1 and fifo_level returns to 4.
REQ-033 mute=1 with head 0x7FFF8000 popped -> sample_l=sample_r=0; mute=0 next cycle -> sample_l=0x7FFF, sample_r=0x8000.
REQ-034 reset pulsed mid-frame with fifo_level=3, underrun_cnt=5 -> next cycle all outputs per REQ-027; enable=0 mid-frame -> no sclk_en, bit_cnt restarts at 0.

Source files
------------

// File: rtl/pocket_audio_sched.sv
// Audio sample scheduler: serial timebase, round-robin intake of two sample-pair
// sources into a small FIFO, and frame-rate hand-off of the FIFO head to the serializer.
`timescale 1ns/1ps
module pocket_audio_sched #(
    parameter int unsigned SCLK_DIV   = 12,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk_74a,
    input  logic        reset,
    input  logic        enable,
    input  logic        mute,
    input  logic        src0_valid,
    input  logic [31:0] src0_data,
    output logic        src0_ready,
    input  logic        src1_valid,
    input  logic [31:0] src1_data,
    output logic        src1_ready,
    output logic        sclk_en,
    output logic        frame_start,
    output logic [15:0] sample_l,
    output logic [15:0] sample_r,
    output logic [4:0]  fifo_level,
    output logic [7:0]  underrun_cnt
);

    localparam int unsigned AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [7:0]  DIV_LAST = 8'(SCLK_DIV - 1);
    localparam logic [4:0]  DEPTH_L  = 5'(FIFO_DEPTH);

    logic [7:0]    div_q, div_d;
    logic [5:0]    bit_q, bit_d;
    logic          last_q, last_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [4:0]    lvl_q, lvl_d;
    logic [15:0]   hold_l_q, hold_l_d;
    logic [15:0]   hold_r_q, hold_r_d;
    logic [7:0]    und_q, und_d;
    logic [31:0]   fifo_mem [FIFO_DEPTH];

    logic          sclk_s;
    logic          frame_s;
    logic          room_s;
    logic          rdy0_s;
    logic          rdy1_s;
    logic          push_s;
    logic          pop_s;
    logic [31:0]   push_data_s;

    // Strobes and arbitration; last_q=1 means src1 won the previous transfer,
    // so src0 is favoured out of reset.
    always_comb begin
        sclk_s      = enable && (div_q == DIV_LAST);
        frame_s     = sclk_s && (bit_q == 6'd63);
        room_s      = !reset && (lvl_q != DEPTH_L);
        rdy0_s      = room_s && src0_valid && (!src1_valid || last_q);
        rdy1_s      = room_s && src1_valid && (!src0_valid || !last_q);
        push_s      = rdy0_s || rdy1_s;
        pop_s       = frame_s && (lvl_q != 5'd0);
        push_data_s = rdy0_s ? src0_data : src1_data;
    end

    // Next-state for timebase, arbitration pointer, FIFO bookkeeping and held samples.
    always_comb begin
        if (!enable) begin
            div_d = 8'd0;
            bit_d = 6'd0;
        end else if (sclk_s) begin
            div_d = 8'd0;
            bit_d = bit_q + 6'd1;
        end else begin
            div_d = div_q + 8'd1;
            bit_d = bit_q;
        end

        if (push_s) begin
            wr_d   = wr_q + AW'(1'b1);
            last_d = rdy1_s;
        end else begin
            wr_d   = wr_q;
            last_d = last_q;
        end

        if (pop_s) begin
            rd_d     = rd_q + AW'(1'b1);
            hold_l_d = fifo_mem[rd_q][31:16];
            hold_r_d = fifo_mem[rd_q][15:0];
        end else begin
            rd_d     = rd_q;
            hold_l_d = hold_l_q;
            hold_r_d = hold_r_q;
        end

        if (frame_s && (lvl_q == 5'd0) && (und_q != 8'hFF)) begin
            und_d = und_q + 8'd1;
        end else begin
            und_d = und_q;
        end

        case ({push_s, pop_s})
            2'b10:   lvl_d = lvl_q + 5'd1;
            2'b01:   lvl_d = lvl_q - 5'd1;
            default: lvl_d = lvl_q;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_74a) begin
        if (reset) begin
            div_q    <= 8'd0;
            bit_q    <= 6'd0;
            last_q   <= 1'b1;
            wr_q     <= '0;
            rd_q     <= '0;
            lvl_q    <= 5'd0;
            hold_l_q <= 16'd0;
            hold_r_q <= 16'd0;
            und_q    <= 8'd0;
        end else begin
            div_q    <= div_d;
            bit_q    <= bit_d;
            last_q   <= last_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            lvl_q    <= lvl_d;
            hold_l_q <= hold_l_d;
            hold_r_q <= hold_r_d;
            und_q    <= und_d;
        end
    end

    // FIFO storage needs no reset: occupancy is tracked by the pointers.
    always_ff @(posedge clk_74a) begin
        if (push_s) begin
            fifo_mem[wr_q] <= push_data_s;
        end
    end

    assign src0_ready   = rdy0_s;
    assign src1_ready   = rdy1_s;
    assign sclk_en      = sclk_s;
    assign frame_start  = frame_s;
    assign sample_l     = mute ? 16'd0 : hold_l_q;
    assign sample_r     = mute ? 16'd0 : hold_r_q;
    assign fifo_level   = lvl_q;
    assign underrun_cnt = und_q;

endmodule

// File: tb/tb_pocket_audio_sched.sv
// Scoreboard bench: accepted sample pairs are queued by the bench and compared
// against the serializer outputs after each frame boundary.
`timescale 1ns/1ps
module tb_pocket_audio_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, enable, mute, v0, v1;
    logic [31:0] d0, d1;
    logic        r0, r1, sclk, fs;
    logic [15:0] sl, sr;
    logic [4:0]  lvl;
    logic [7:0]  und;

    logic        reset2, enable2;
    logic        r0_2, r1_2, sclk2, fs2;
    logic [15:0] sl2, sr2;
    logic [4:0]  lvl2;
    logic [7:0]  und2;
    int          nfr2 = 0;

    int n_cmp = 0;
    int n_bad = 0;

    pocket_audio_sched #(.SCLK_DIV(4), .FIFO_DEPTH(4)) dut (
        .clk_74a(clk), .reset(reset), .enable(enable), .mute(mute),
        .src0_valid(v0), .src0_data(d0), .src0_ready(r0),
        .src1_valid(v1), .src1_data(d1), .src1_ready(r1),
        .sclk_en(sclk), .frame_start(fs), .sample_l(sl), .sample_r(sr),
        .fifo_level(lvl), .underrun_cnt(und)
    );

    pocket_audio_sched #(.SCLK_DIV(2), .FIFO_DEPTH(2)) u_sat (
        .clk_74a(clk), .reset(reset2), .enable(enable2), .mute(1'b0),
        .src0_valid(1'b0), .src0_data(32'd0), .src0_ready(r0_2),
        .src1_valid(1'b0), .src1_data(32'd0), .src1_ready(r1_2),
        .sclk_en(sclk2), .frame_start(fs2), .sample_l(sl2), .sample_r(sr2),
        .fifo_level(lvl2), .underrun_cnt(und2)
    );

    always @(posedge clk) begin
        if (fs2) nfr2 <= nfr2 + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Stimulus schedule indexed by cycle number after reset release.
    task automatic drive(input int c);
        reset  = (c == 2950);
        enable = !(c >= 3100 && c <= 3110);
        mute   = (c == 2304) || (c == 2305);
        v0     = (c >= 1 && c <= 4) || (c == 2100) || (c >= 2900 && c <= 2902);
        v1     = (c >= 1 && c <= 257) || (c == 2950);
        d0     = (c == 2100) ? 32'h7FFF8000 : ((c >= 2900) ? (32'h0BAD0000 | 32'(c)) : 32'h11112222);
        d1     = (c <= 4) ? 32'h33334444 : ((c == 2950) ? 32'hDEADBEEF : 32'hAAAA5555);
    endtask

    initial begin
        logic [31:0] exp_q[$];
        logic [31:0] w;
        logic [15:0] m_l, m_r;
        int          m_div, m_bit, m_und, guard;
        logic        m_last, e_sclk, e_fs, e_r0, e_r1;

        reset = 1'b1; reset2 = 1'b1; enable = 1'b1; enable2 = 1'b0; mute = 1'b0;
        v0 = 1'b1; v1 = 1'b1; d0 = 32'h11112222; d1 = 32'h33334444;
        repeat (3) tick();
        #1;
        check_val("rst_ready0", 32'(r0), 32'd0);
        check_val("rst_ready1", 32'(r1), 32'd0);
        check_val("rst_level", 32'(lvl), 32'd0);
        check_val("rst_sample_l", 32'(sl), 32'd0);
        check_val("rst_sample_r", 32'(sr), 32'd0);
        check_val("rst_underrun", 32'(und), 32'd0);
        check_val("rst_sclk_en", 32'(sclk), 32'd0);
        check_val("rst_frame_start", 32'(fs), 32'd0);

        m_div = 0; m_bit = 0; m_und = 0; m_l = 16'd0; m_r = 16'd0; m_last = 1'b1;
        reset2 = 1'b0; enable2 = 1'b1;

        for (int c = 1; c <= 3400; c++) begin
            drive(c);
            #1;
            e_sclk = enable && (m_div == 3);
            e_fs   = e_sclk && (m_bit == 63);
            e_r0   = !reset && (exp_q.size() < 4) && v0 && (!v1 || m_last);
            e_r1   = !reset && (exp_q.size() < 4) && v1 && (!v0 || !m_last);
            check_val("src0_ready", 32'(r0), 32'(e_r0));
            check_val("src1_ready", 32'(r1), 32'(e_r1));
            check_val("sclk_en", 32'(sclk), 32'(e_sclk));
            check_val("frame_start", 32'(fs), 32'(e_fs));
            check_val("fifo_level", 32'(lvl), 32'(exp_q.size()));
            check_val("sample_l", 32'(sl), mute ? 32'd0 : 32'(m_l));
            check_val("sample_r", 32'(sr), mute ? 32'd0 : 32'(m_r));
            check_val("underrun_cnt", 32'(und), 32'(m_und));

            if (reset) begin
                m_div = 0; m_bit = 0; m_und = 0; m_l = 16'd0; m_r = 16'd0; m_last = 1'b1;
                exp_q.delete();
            end else begin
                if (!enable) begin
                    m_div = 0; m_bit = 0;
                end else if (e_sclk) begin
                    m_div = 0; m_bit = (m_bit + 1) % 64;
                end else begin
                    m_div = m_div + 1;
                end
                if (e_fs) begin
                    if (exp_q.size() > 0) begin
                        w = exp_q.pop_front();
                        m_l = w[31:16];
                        m_r = w[15:0];
                    end else if (m_und < 255) begin
                        m_und = m_und + 1;
                    end
                end
                if (e_r0) begin
                    exp_q.push_back(d0);
                    m_last = 1'b0;
                end else if (e_r1) begin
                    exp_q.push_back(d1);
                    m_last = 1'b1;
                end
            end
            tick();
        end

        guard = 0;
        while (nfr2 < 254 && guard < 60000) begin
            tick();
            guard++;
        end
        check_val("sat_reach_254", 32'(nfr2), 32'd254);
        check_val("sat_underrun_254", 32'(und2), 32'd254);
        guard = 0;
        while (nfr2 < 300 && guard < 20000) begin
            tick();
            guard++;
        end
        check_val("sat_reach_300", 32'(nfr2), 32'd300);
        check_val("sat_underrun_255", 32'(und2), 32'd255);
        check_val("sat_level", 32'(lvl2), 32'd0);
        check_val("sat_sample", {sl2, sr2}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
